// File: rtl/branch_pc_unit_if.sv
// rtl/branch_pc_unit_if.sv - control/status bundle between decode and the branch/PC unit
interface branch_pc_unit_if #(
  parameter int STACK_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

  logic             stall;
  logic             is_branch;
  logic             jump;
  logic             is_call;
  logic             is_ret;
  logic [15:0]      target;
  logic             clear_err;
  logic [15:0]      pc;
  logic             flush;
  logic             stack_overflow;
  logic             stack_underflow;
  logic [CNT_W-1:0] stack_count;

  modport master (
    output stall, is_branch, jump, is_call, is_ret, target, clear_err,
    input  pc, flush, stack_overflow, stack_underflow, stack_count
  );

  modport slave (
    input  stall, is_branch, jump, is_call, is_ret, target, clear_err,
    output pc, flush, stack_overflow, stack_underflow, stack_count
  );
endinterface

// File: rtl/branch_pc_unit.sv
// rtl/branch_pc_unit.sv - program counter with branch/call/return redirect and circular return stack
module branch_pc_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          STACK_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  branch_pc_unit_if.slave  bus
);
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(STACK_DEPTH);

  logic [15:0]      pc_q, pc_d;
  logic             flush_q, flush_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [15:0]      stack_q [STACK_DEPTH];

  logic             push;
  logic [15:0]      pc_inc;
  logic [PTR_W-1:0] sp_m1;

  assign pc_inc = pc_q + 16'd1;
  assign sp_m1  = sp_q - PTR_W'(1);

  // sp_q always names the next free slot; when full it wraps onto the oldest entry,
  // so a push while full overwrites that entry without extra bookkeeping.
  always_comb begin
    pc_d    = pc_inc;
    flush_d = 1'b0;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    push    = 1'b0;
    ovf_d   = bus.clear_err ? 1'b0 : ovf_q;
    unf_d   = bus.clear_err ? 1'b0 : unf_q;

    if (bus.stall) begin
      pc_d  = pc_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
    end else if (bus.is_ret) begin
      if (cnt_q != '0) begin
        pc_d    = stack_q[sp_m1];
        sp_d    = sp_m1;
        cnt_d   = cnt_q - CNT_W'(1);
        flush_d = 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end else if (bus.is_call) begin
      push    = 1'b1;
      pc_d    = bus.target;
      sp_d    = sp_q + PTR_W'(1);
      flush_d = 1'b1;
      if (cnt_q == FULL) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (bus.is_branch && bus.jump) begin
      pc_d    = bus.target;
      flush_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cnt_q   <= '0;
      sp_q    <= '0;
    end else begin
      pc_q    <= pc_d;
      flush_q <= flush_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
    end
  end

  // Entry contents are don't-care after reset; only the pointer and count are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

  assign bus.pc              = pc_q;
  assign bus.flush           = flush_q;
  assign bus.stack_overflow  = ovf_q;
  assign bus.stack_underflow = unf_q;
  assign bus.stack_count     = cnt_q;
endmodule

// File: tb/tb_branch_pc_unit.sv
// tb/tb_branch_pc_unit.sv - scoreboard bench for branch_pc_unit
module tb_branch_pc_unit;
  logic clk;
  logic rst_n;

  branch_pc_unit_if #(.STACK_DEPTH(4)) bus ();

  branch_pc_unit #(.RESET_PC(16'h0000), .STACK_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        fl;
    logic [2:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb_q [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    n_tests++;
    if (bus.pc !== e.pc) begin
      n_fail++;
      $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc);
    end
    n_tests++;
    if (bus.flush !== e.fl) begin
      n_fail++;
      $display("FAIL %s flush: got %b expected %b", e.name, bus.flush, e.fl);
    end
    n_tests++;
    if (bus.stack_count !== e.cnt) begin
      n_fail++;
      $display("FAIL %s stack_count: got %0d expected %0d", e.name, bus.stack_count, e.cnt);
    end
    n_tests++;
    if (bus.stack_overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL %s stack_overflow: got %b expected %b", e.name, bus.stack_overflow, e.ovf);
    end
    n_tests++;
    if (bus.stack_underflow !== e.unf) begin
      n_fail++;
      $display("FAIL %s stack_underflow: got %b expected %b", e.name, bus.stack_underflow, e.unf);
    end
  endtask

  // Monitor: the unit presents a new state after every edge; sample it on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      check(sb_q.pop_front());
    end
  end

  // Called at negedge+1: drive one cycle of inputs, queue the post-edge state, wait past the next negedge.
  task automatic step(input string name, input logic st, input logic br, input logic jp,
                      input logic cl, input logic rt, input logic [15:0] tg, input logic ce,
                      input logic [15:0] e_pc, input logic e_fl, input logic [2:0] e_cnt,
                      input logic e_ovf, input logic e_unf);
    exp_t e;
    bus.stall     = st;
    bus.is_branch = br;
    bus.jump      = jp;
    bus.is_call   = cl;
    bus.is_ret    = rt;
    bus.target    = tg;
    bus.clear_err = ce;
    e.name = name; e.pc = e_pc; e.fl = e_fl; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
    sb_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t r;
    rst_n = 1'b0;
    bus.stall = 0; bus.is_branch = 0; bus.jump = 0; bus.is_call = 0;
    bus.is_ret = 0; bus.target = 16'h0000; bus.clear_err = 0;
    #2;
    r.name = "reset"; r.pc = 16'h0000; r.fl = 0; r.cnt = 0; r.ovf = 0; r.unf = 0;
    check(r);
    #9;
    rst_n = 1'b1;

    //    name          st br jp cl rt target    ce  pc        fl cnt ovf unf
    step("idle1",       0, 0, 0, 0, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0);
    step("idle2",       0, 0, 0, 0, 0, 16'h0000, 0, 16'h0002, 0, 0, 0, 0);
    step("idle3",       0, 0, 0, 0, 0, 16'h0000, 0, 16'h0003, 0, 0, 0, 0);
    step("br_to_10",    0, 1, 1, 0, 0, 16'h0010, 0, 16'h0010, 1, 0, 0, 0);
    step("br_taken",    0, 1, 1, 0, 0, 16'h0040, 0, 16'h0040, 1, 0, 0, 0);
    step("br_to_10b",   0, 1, 1, 0, 0, 16'h0010, 0, 16'h0010, 1, 0, 0, 0);
    step("br_not",      0, 1, 0, 0, 0, 16'h0040, 0, 16'h0011, 0, 0, 0, 0);
    step("br_to_100",   0, 1, 1, 0, 0, 16'h0100, 0, 16'h0100, 1, 0, 0, 0);
    step("call1",       0, 0, 0, 1, 0, 16'h0200, 0, 16'h0200, 1, 1, 0, 0);
    step("call2",       0, 0, 0, 1, 0, 16'h0300, 0, 16'h0300, 1, 2, 0, 0);
    step("call3",       0, 0, 0, 1, 0, 16'h0400, 0, 16'h0400, 1, 3, 0, 0);
    step("call4",       0, 1, 0, 1, 0, 16'h0500, 0, 16'h0500, 1, 4, 0, 0);
    step("ret1",        0, 0, 0, 0, 1, 16'h0000, 0, 16'h0401, 1, 3, 0, 0);
    step("ret2",        0, 0, 0, 0, 1, 16'h0000, 0, 16'h0301, 1, 2, 0, 0);
    step("ret3",        0, 0, 0, 0, 1, 16'h0000, 0, 16'h0201, 1, 1, 0, 0);
    step("ret4",        0, 0, 0, 0, 1, 16'h0000, 0, 16'h0101, 1, 0, 0, 0);
    step("ocall1",      0, 0, 0, 1, 0, 16'h1000, 0, 16'h1000, 1, 1, 0, 0);
    step("ocall2",      0, 0, 0, 1, 0, 16'h2000, 0, 16'h2000, 1, 2, 0, 0);
    step("ocall3",      0, 0, 0, 1, 0, 16'h3000, 0, 16'h3000, 1, 3, 0, 0);
    step("ocall4",      0, 0, 0, 1, 0, 16'h4000, 0, 16'h4000, 1, 4, 0, 0);
    step("ocall5_full", 0, 0, 0, 1, 0, 16'h5000, 0, 16'h5000, 1, 4, 1, 0);
    step("oret1",       0, 0, 0, 0, 1, 16'h0000, 0, 16'h4001, 1, 3, 1, 0);
    step("oret2",       0, 0, 0, 0, 1, 16'h0000, 0, 16'h3001, 1, 2, 1, 0);
    step("oret3",       0, 0, 0, 0, 1, 16'h0000, 0, 16'h2001, 1, 1, 1, 0);
    step("oret4",       0, 0, 0, 0, 1, 16'h0000, 0, 16'h1001, 1, 0, 1, 0);
    step("oret5_empty", 0, 0, 0, 0, 1, 16'h0000, 0, 16'h1002, 0, 0, 1, 1);
    step("clear",       0, 0, 0, 0, 0, 16'h0000, 1, 16'h1003, 0, 0, 0, 0);
    step("clr_setwins", 0, 0, 0, 0, 1, 16'h0000, 1, 16'h1004, 0, 0, 0, 1);
    step("clear2",      0, 0, 0, 0, 0, 16'h0000, 1, 16'h1005, 0, 0, 0, 0);
    step("callret_emp", 0, 0, 0, 1, 1, 16'h7777, 0, 16'h1006, 0, 0, 0, 1);
    step("clear3",      0, 0, 0, 0, 0, 16'h0000, 1, 16'h1007, 0, 0, 0, 0);
    step("call_pre",    0, 0, 0, 1, 0, 16'h2000, 0, 16'h2000, 1, 1, 0, 0);
    step("callret",     0, 1, 1, 1, 1, 16'h7777, 0, 16'h1008, 1, 0, 0, 0);
    step("br_to_ffff",  0, 1, 1, 0, 0, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, 0);
    step("wrap",        0, 0, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
    step("br_to_50",    0, 1, 1, 0, 0, 16'h0050, 0, 16'h0050, 1, 0, 0, 0);
    step("stall_br",    1, 1, 1, 0, 0, 16'h0040, 0, 16'h0050, 0, 0, 0, 0);
    step("stall_ret",   1, 0, 0, 0, 1, 16'h0000, 0, 16'h0050, 0, 0, 0, 0);
    step("stall_call",  1, 0, 0, 1, 0, 16'h0060, 0, 16'h0050, 0, 0, 0, 0);
    step("call_60",     0, 0, 0, 1, 0, 16'h0060, 0, 16'h0060, 1, 1, 0, 0);

    // Reset dropped between edges while a call is being presented.
    bus.is_call = 1'b1;
    bus.target  = 16'h0070;
    #2;
    rst_n = 1'b0;
    #1;
    r.name = "async_reset"; r.pc = 16'h0000; r.fl = 0; r.cnt = 0; r.ovf = 0; r.unf = 0;
    check(r);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    step("post_rst",    0, 0, 0, 0, 0, 16'h0000, 0, 16'h0001, 0, 0, 0, 0);
    step("post_rst_rt", 0, 0, 0, 0, 1, 16'h0000, 0, 16'h0002, 0, 0, 0, 1);

    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_pc_unit.md
BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the PC value loaded on reset.
REQ-002 Parameter STACK_DEPTH, default 4, is the return-address stack depth in entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  1 = hold all state this cycle.
REQ-006 is_branch  input  1  current instruction is a conditional branch/jump.
REQ-007 jump  input  1  branch-taken decision from the compare stage (Rd vs Rs/N, or SUB zero result).
REQ-008 is_call  input  1  current instruction is a subroutine call (unconditional).
REQ-009 is_ret  input  1  current instruction is a subroutine return.
REQ-010 target  input  16  branch/call destination address.
REQ-011 clear_err  input  1  clears sticky error flags.
REQ-012 pc  output  16  registered current program counter.
REQ-013 flush  output  1  registered one-cycle pulse: the previous cycle redirected the PC.
REQ-014 stack_overflow  output  1  sticky: a call was made with the stack full.
REQ-015 stack_underflow  output  1  sticky: a return was made with the stack empty.
REQ-016 stack_count  output  log2(STACK_DEPTH)+1  number of valid stack entries.

Function
REQ-017 When stall=1, pc, stack contents, stack pointer, stack_count and sticky flags SHALL hold, and flush SHALL be 0 on the next edge.
REQ-018 When not stalled, next-PC selection SHALL use this priority: is_ret > is_call > (is_branch & jump) > sequential.
REQ-019 Sequential: pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
REQ-020 Taken branch (is_branch=1, jump=1, no call/ret): pc <= target; flush <= 1.
REQ-021 Not-taken branch (is_branch=1, jump=0): pc <= pc + 1; flush <= 0.
REQ-022 Call: push (pc + 1) mod 2^16; pc <= target; flush <= 1; jump is ignored.
REQ-023 Return with stack non-empty: pop the top entry; pc <= popped value; flush <= 1.
REQ-024 Return with stack empty: pc <= pc + 1; stack unchanged; stack_underflow <= 1; flush <= 0.
REQ-025 Call with stack full (stack_count = STACK_DEPTH): the oldest entry SHALL be overwritten (circular buffer); stack_count stays STACK_DEPTH; stack_overflow <= 1; the redirect proceeds normally.
REQ-026 is_call and is_ret both 1: the return SHALL be executed and the call ignored (no push).
REQ-027 flush SHALL be 1 for exactly one cycle after each redirect; back-to-back redirects SHALL produce consecutive flush pulses.
REQ-028 clear_err=1 (not stalled) SHALL clear both sticky flags; if an error event occurs in the same cycle, the flag SHALL be set (set wins).
REQ-029 Stack is LIFO: after N pushes (N <= STACK_DEPTH), N pops SHALL return addresses in reverse push order.
REQ-030 Outputs SHALL be driven only from registers; no combinational path from inputs to outputs.

Reset
REQ-031 rst_n=0 SHALL immediately, without waiting for clk, set pc=RESET_PC, flush=0, stack_count=0, stack pointer=0, stack_overflow=0, stack_underflow=0; stack entry contents need not be cleared.
REQ-032 Reset asserted mid-operation (including during stall or pending flush) SHALL discard all in-flight state; first edge after release behaves as a cycle from a reset state.
REQ-033 Deassertion SHALL be treated as synchronous to clk; no state changes on the deasserting edge other than the normal cycle update.

Verification
REQ-034 Reset, then 3 idle cycles -> pc = 0000, 0001, 0002, 0003; flush=0 throughout.
REQ-035 pc=0010, is_branch=1, jump=1, target=0040 -> pc=0040, flush=1 for one cycle; repeat with jump=0 -> pc=0011, flush=0.
REQ-036 Calls at pc=0100, 0200, 0300, 0400 to targets 0200, 0300, 0400, 0500 then 4 returns -> pc sequence 0401, 0301, 0201, 0101; stack_count 4->0.
REQ-037 STACK_DEPTH=4: 5 calls -> stack_overflow=1, count=4, first pushed address lost; 5 returns -> 5th return gives pc+1 and stack_underflow=1; clear_err -> both flags 0.
REQ-038 pc=FFFF, sequential -> pc=0000; stall=1 with is_branch=1, jump=1 -> pc holds, flush=0.
REQ-039 Assert rst_n=0 between clock edges during a call -> pc=RESET_PC and stack_count=0 immediately, before the next edge.
